// File: rtl/register_8bit_arbiter_pkg.sv
// Package exposing register width, default requester count and reset value.
// No logic, no latency.
// Constants only; flow control lives in the arbiter.
package register_8bit_arbiter_pkg;

`include "register_defs.vh"

    localparam int             REG_W       = `REG_WIDTH;
    localparam int             DEF_NREQ    = `REG_DEF_NREQ;
    localparam logic [REG_W-1:0] REG_RST_VAL = `REG_RST_VAL;

endpackage

// File: rtl/register_8bit.sv
// 8-bit storage register with load enable and synchronous active-high reset.
// Latency: data_in captured on the rising edge where lode is high.
// No backpressure: a load is always accepted; without lode the value holds.
module register_8bit
    import register_8bit_arbiter_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             lode,
    input  logic [REG_W-1:0] data_in,
    output logic [REG_W-1:0] data_out
);

    logic [REG_W-1:0] data_d;
    logic [REG_W-1:0] data_q;

    // Next value: load when enabled, otherwise keep.
    always_comb begin
        data_d = data_q;
        if (lode) begin
            data_d = data_in;
        end
    end

    // Storage flop; reset wins over any load.
    always_ff @(posedge CLK) begin
        if (RST) begin
            data_q <= REG_RST_VAL;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_out = data_q;

endmodule

// File: rtl/register_defs.vh
// Shared constants for the 8-bit register and its write arbiter.
// Pure definitions; no logic, no latency.
// Included by the package so every consumer sees one set of values.
`ifndef REGISTER_DEFS_VH
`define REGISTER_DEFS_VH

`define REG_WIDTH    8
`define REG_DEF_NREQ 4
`define REG_RST_VAL  8'h00

`endif

// File: rtl/register_8bit_arbiter.sv
// Round-robin write arbiter sharing one register_8bit between NREQ requesters.
// Latency: grant is combinational; granted data is visible after the next edge.
// Losers keep req high and wait; hold or RST suppresses all grants.
module register_8bit_arbiter
    import register_8bit_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NREQ-1:0]       req,
    input  logic [8*NREQ-1:0]     data_in,
    input  logic                  hold,
    output logic [NREQ-1:0]       grant,
    output logic [7:0]            data_out,
    output logic [IDW-1:0]        last_id,
    output logic                  loaded,
    output logic [7:0]            wr_count
);

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    logic [IDW-1:0] ptr_d, ptr_q;
    logic [IDW-1:0] last_id_d, last_id_q;
    logic           loaded_d, loaded_q;
    logic [7:0]     wr_count_d, wr_count_q;

    logic           found;
    logic [IDW-1:0] sel_id;
    logic [IDW:0]   sum;
    logic [7:0]     sel_data;

    // Pick the first requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        grant  = '0;
        found  = 1'b0;
        sel_id = '0;
        sum    = '0;
        if (!RST && !hold) begin
            for (int k = 0; k < NREQ; k++) begin
                sum = {1'b0, ptr_q} + (IDW+1)'(k);
                if (sum >= NREQ_W) begin
                    sum = sum - NREQ_W;
                end
                if (!found && req[sum[IDW-1:0]]) begin
                    found  = 1'b1;
                    sel_id = sum[IDW-1:0];
                end
            end
        end
        if (found) begin
            grant[sel_id] = 1'b1;
        end
    end

    // Route the winner's byte to the shared register.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_id == IDW'(i)) begin
                sel_data = data_in[8*i +: 8];
            end
        end
    end

    // Bookkeeping updates only on a granted edge.
    always_comb begin
        ptr_d      = ptr_q;
        last_id_d  = last_id_q;
        loaded_d   = loaded_q;
        wr_count_d = wr_count_q;
        if (found) begin
            ptr_d      = (sel_id == IDW'(NREQ-1)) ? '0 : sel_id + IDW'(1);
            last_id_d  = sel_id;
            loaded_d   = 1'b1;
            wr_count_d = wr_count_q + 8'd1;
        end
    end

    // Arbiter state flops with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q      <= '0;
            last_id_q  <= '0;
            loaded_q   <= 1'b0;
            wr_count_q <= 8'd0;
        end else begin
            ptr_q      <= ptr_d;
            last_id_q  <= last_id_d;
            loaded_q   <= loaded_d;
            wr_count_q <= wr_count_d;
        end
    end

    register_8bit u_reg (
        .CLK      (CLK),
        .RST      (RST),
        .lode     (|grant),
        .data_in  (sel_data),
        .data_out (data_out)
    );

    assign last_id  = last_id_q;
    assign loaded   = loaded_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_register_8bit_arbiter.sv
// Self-checking bench for register_8bit_arbiter against a behavioural model.
// Directed scenarios followed by randomized traffic, holds and resets.
// One summary line at the end.
module tb_register_8bit_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] data_in;
    logic              hold;
    logic [NREQ-1:0]   grant;
    logic [7:0]        data_out;
    logic [IDW-1:0]    last_id;
    logic              loaded;
    logic [7:0]        wr_count;

    register_8bit_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .CLK      (clk),
        .RST      (rst),
        .req      (req),
        .data_in  (data_in),
        .hold     (hold),
        .grant    (grant),
        .data_out (data_out),
        .last_id  (last_id),
        .loaded   (loaded),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state, kept as plain integers.
    int m_ptr    = 0;
    int m_data   = 0;
    int m_last   = 0;
    int m_loaded = 0;
    int m_count  = 0;
    int m_writes = 0;
    logic [NREQ-1:0] g_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack4(input int b0, input int b1, input int b2, input int b3);
        return {b3[7:0], b2[7:0], b1[7:0], b0[7:0]};
    endfunction

    // One clock cycle: drive, check grant mid-cycle, update model at edge, check state.
    task automatic step(input logic [NREQ-1:0] r, input logic [31:0] d,
                        input logic h, input logic rs);
        int win;
        logic [NREQ-1:0] exp_g;
        int bytes[NREQ];
        @(negedge clk);
        req = r; data_in = d; hold = h; rst = rs;
        #1;
        win = -1;
        if (!rs && !h) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (win < 0 && r[i]) win = i;
            end
        end
        exp_g = '0;
        if (win >= 0) exp_g[win] = 1'b1;
        g_seen = grant;
        chk("grant", 32'(grant), 32'(exp_g));
        for (int i = 0; i < NREQ; i++) bytes[i] = int'(d[8*i +: 8]);
        @(posedge clk);
        if (rs) begin
            m_ptr = 0; m_data = 0; m_last = 0; m_loaded = 0; m_count = 0;
        end else if (win >= 0) begin
            m_data   = bytes[win];
            m_last   = win;
            m_loaded = 1;
            m_count  = (m_count + 1) % 256;
            m_ptr    = (win + 1) % NREQ;
            m_writes++;
        end
        #1;
        chk("data_out", 32'(data_out), 32'(m_data));
        chk("last_id",  32'(last_id),  32'(m_last));
        chk("loaded",   32'(loaded),   32'(m_loaded));
        chk("wr_count", 32'(wr_count), 32'(m_count));
    endtask

    initial begin
        logic [31:0] rr_dat;
        int guard;
        req = '0; data_in = '0; hold = 1'b0; rst = 1'b1;

        // Reset with every request raised.
        step(4'b1111, 32'hDEADBEEF, 1'b0, 1'b1);
        chk("rst_grant0", 32'(g_seen), 32'h0);
        step(4'b1111, 32'hDEADBEEF, 1'b0, 1'b1);
        chk("rst_grant1", 32'(g_seen), 32'h0);
        chk("rst_data", 32'(data_out), 32'h00);
        chk("rst_cnt",  32'(wr_count), 32'h0);
        chk("rst_ld",   32'(loaded),   32'h0);
        chk("rst_id",   32'(last_id),  32'h0);

        // Single requester 2.
        step(4'b0100, pack4(8'hA0, 8'hA1, 8'h55, 8'hA3), 1'b0, 1'b0);
        chk("single_grant", 32'(g_seen), 32'h4);
        chk("single_data", 32'(data_out), 32'h55);
        chk("single_id",   32'(last_id),  32'h2);
        chk("single_cnt",  32'(wr_count), 32'h1);
        chk("single_ld",   32'(loaded),   32'h1);

        // Round robin from a fresh pointer.
        step(4'b0000, 32'h0, 1'b0, 1'b1);
        rr_dat = pack4(8'h11, 8'h22, 8'h33, 8'h44);
        for (int c = 0; c < 5; c++) begin
            step(4'b1111, rr_dat, 1'b0, 1'b0);
            chk("rr_grant", 32'(g_seen), 32'(1 << (c % 4)));
            chk("rr_data",  32'(data_out), 32'((c % 4 + 1) * 8'h11));
        end
        chk("rr_cnt", 32'(wr_count), 32'd5);

        // Hold suppresses grants; release grants in the same cycle.
        for (int c = 0; c < 3; c++) begin
            step(4'b0010, pack4(8'h01, 8'h77, 8'h03, 8'h04), 1'b1, 1'b0);
            chk("hold_grant", 32'(g_seen), 32'h0);
            chk("hold_data",  32'(data_out), 32'h11);
        end
        step(4'b0010, pack4(8'h01, 8'h77, 8'h03, 8'h04), 1'b0, 1'b0);
        chk("unhold_grant", 32'(g_seen), 32'h2);
        chk("unhold_data",  32'(data_out), 32'h77);

        // Contention after pointer moves past 3.
        step(4'b1000, pack4(8'h00, 8'h00, 8'h00, 8'h9C), 1'b0, 1'b0);
        chk("p3_grant", 32'(g_seen), 32'h8);
        step(4'b1010, pack4(8'h00, 8'hB1, 8'h00, 8'hB3), 1'b0, 1'b0);
        chk("cont_g1", 32'(g_seen), 32'h2);
        step(4'b1010, pack4(8'h00, 8'hB1, 8'h00, 8'hB3), 1'b0, 1'b0);
        chk("cont_g3", 32'(g_seen), 32'h8);
        chk("cont_data", 32'(data_out), 32'hB3);

        // 256 writes of random traffic wrap the counter to zero.
        step(4'b0000, 32'h0, 1'b0, 1'b1);
        m_writes = 0;
        guard = 0;
        while (m_writes < 256 && guard < 4000) begin
            step(NREQ'($urandom), $urandom, ($urandom_range(0, 7) == 0), 1'b0);
            guard++;
        end
        chk("wrap_done", 32'(m_writes), 32'd256);
        chk("wrap_cnt",  32'(wr_count), 32'd0);
        chk("wrap_ld",   32'(loaded),   32'd1);

        // Reset during a cycle that would otherwise grant.
        step(4'b1111, 32'hCAFEF00D, 1'b0, 1'b1);
        chk("midrst_grant", 32'(g_seen), 32'h0);
        chk("midrst_data",  32'(data_out), 32'h00);
        chk("midrst_ld",    32'(loaded),   32'h0);
        chk("midrst_cnt",   32'(wr_count), 32'h0);

        // Random mix including occasional resets.
        for (int c = 0; c < 300; c++) begin
            step(NREQ'($urandom), $urandom, ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 40) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
